// File: rtl/tinyalu_pkg.sv
// Shared TinyALU definitions: opcode encoding, driver FSM states and the illegal-opcode check.
package tinyalu_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        NO_OP  = 3'b000,
        ADD_OP = 3'b001,
        AND_OP = 3'b010,
        XOR_OP = 3'b011,
        MUL_OP = 3'b100,
        RST_OP = 3'b111
    } operation_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        NOP,
        RST
    } state_t;

    // 101 and 110 are unassigned and get dropped by the driver.
    function automatic logic op_is_illegal(input logic [OP_W-1:0] op);
        return (op == 3'b101) || (op == 3'b110);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for alu_cmd_driver: stores {op, b, a} entries, reports full/empty.
module alu_cmd_fifo
    import tinyalu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    push,
    input  logic [2*WIDTH+OP_W-1:0] wr_data,
    input  logic                    pop,
    output logic [2*WIDTH+OP_W-1:0] rd_data,
    output logic                    full,
    output logic                    empty
);

    localparam int ENTRY_W = 2*WIDTH + OP_W;
    localparam int PTR_W   = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/alu_cmd_driver.sv
// TinyALU command driver: queues commands and issues them over the start/done handshake.
// Optional statistics counters are enabled by defining ALU_CMD_DRIVER_STATS_EN.
module alu_cmd_driver
    import tinyalu_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 4,
    parameter int TIMEOUT    = 16,
    parameter int RST_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [WIDTH-1:0]   cmd_a,
    input  logic [WIDTH-1:0]   cmd_b,
    input  logic [2:0]         cmd_op,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [2:0]         alu_op,
    output logic               alu_start,
    input  logic               alu_done,
    input  logic [2*WIDTH-1:0] alu_result,
    output logic               alu_reset_n,
    output logic               rsp_valid,
    output logic [2*WIDTH-1:0] rsp_result,
    output logic [2:0]         rsp_op,
    output logic               err_timeout,
    output logic               busy
`ifdef ALU_CMD_DRIVER_STATS_EN
    ,
    output logic [31:0]        stat_issued,
    output logic [31:0]        stat_done,
    output logic [15:0]        stat_timeout
`endif
);

    localparam int ENTRY_W = 2*WIDTH + OP_W;
    localparam int CNT_MAX = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    state_t             state_q;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt_q;
    logic [ENTRY_W-1:0] head;
    logic [OP_W-1:0]    head_op;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               load;
    logic               cap;
    logic               tmo;
    logic               alu_rst_rel_q;

    alu_cmd_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (cmd_valid),
        .wr_data ({cmd_op, cmd_b, cmd_a}),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign head_op     = head[ENTRY_W-1 -: OP_W];
    assign cmd_ready   = !fifo_full;
    assign busy        = (state_q != IDLE) || !fifo_empty;
    assign alu_start   = (state_q == ISSUE) || (state_q == NOP);
    assign alu_reset_n = alu_rst_rel_q && (state_q != RST);

    always_comb begin
        state_nxt = state_q;
        pop       = 1'b0;
        load      = 1'b0;
        cap       = 1'b0;
        tmo       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (!op_is_illegal(head_op)) begin
                        load = 1'b1;
                        case (head_op)
                            NO_OP:   state_nxt = NOP;
                            RST_OP:  state_nxt = RST;
                            default: state_nxt = ISSUE;
                        endcase
                    end
                end
            end
            ISSUE: begin
                // A done arriving on the last allowed cycle still counts as a response.
                if (alu_done) begin
                    cap       = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    tmo       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            NOP: state_nxt = IDLE;
            RST: begin
                if (cnt_q == CNT_W'(RST_CYCLES - 1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The wait counter sits at zero in IDLE so every operation starts its count fresh.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            alu_rst_rel_q <= 1'b0;
        end else begin
            state_q       <= state_nxt;
            alu_rst_rel_q <= 1'b1;
            if (state_q == IDLE) cnt_q <= '0;
            else                 cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_op      <= '0;
            err_timeout <= 1'b0;
        end else begin
            rsp_valid   <= cap;
            err_timeout <= tmo;
            if (load) begin
                alu_a  <= head[WIDTH-1:0];
                alu_b  <= head[2*WIDTH-1:WIDTH];
                alu_op <= head_op;
            end
            if (cap) begin
                rsp_result <= alu_result;
                rsp_op     <= alu_op;
            end
        end
    end

`ifdef ALU_CMD_DRIVER_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_issued  <= '0;
            stat_done    <= '0;
            stat_timeout <= '0;
        end else begin
            if (load && (stat_issued != '1))  stat_issued  <= stat_issued + 1'b1;
            if (cap && (stat_done != '1))     stat_done    <= stat_done + 1'b1;
            if (tmo && (stat_timeout != '1))  stat_timeout <= stat_timeout + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Self-checking bench for alu_cmd_driver: behavioural ALU responder, event monitor and
// a command-level reference model built from the opcode/latency/timeout rules.
module tb_alu_cmd_driver;

    localparam int WIDTH      = 8;
    localparam int DEPTH      = 4;
    localparam int TIMEOUT    = 16;
    localparam int RST_CYCLES = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_a = '0;
    logic [7:0]  cmd_b = '0;
    logic [2:0]  cmd_op = '0;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_op;
    logic        alu_start;
    logic        alu_done = 1'b0;
    logic [15:0] alu_result = '0;
    logic        alu_reset_n;
    logic        rsp_valid;
    logic [15:0] rsp_result;
    logic [2:0]  rsp_op;
    logic        err_timeout;
    logic        busy;
`ifdef ALU_CMD_DRIVER_STATS_EN
    logic [31:0] stat_issued;
    logic [31:0] stat_done;
    logic [15:0] stat_timeout;
`endif

    int total = 0;
    int bad   = 0;

    // ALU latency per opcode, in start-high cycles; 0 means the ALU never answers.
    int lat_by_op [8];

    string obs_issue = "", exp_issue = "";
    string obs_len   = "", exp_len   = "";
    string obs_rst   = "", exp_rst   = "";
    string obs_rsp   = "", exp_rsp   = "";
    int    obs_tmo   = 0,  exp_tmo   = 0;
    logic [18:0] last_rsp = '0;

    alu_cmd_driver #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .TIMEOUT    (TIMEOUT),
        .RST_CYCLES (RST_CYCLES)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_op       (cmd_op),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_start    (alu_start),
        .alu_done     (alu_done),
        .alu_result   (alu_result),
        .alu_reset_n  (alu_reset_n),
        .rsp_valid    (rsp_valid),
        .rsp_result   (rsp_result),
        .rsp_op       (rsp_op),
        .err_timeout  (err_timeout),
        .busy         (busy)
`ifdef ALU_CMD_DRIVER_STATS_EN
        ,
        .stat_issued  (stat_issued),
        .stat_done    (stat_done),
        .stat_timeout (stat_timeout)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'b001:  return 16'(a) + 16'(b);
            3'b010:  return {8'h00, a & b};
            3'b011:  return {8'h00, a ^ b};
            3'b100:  return 16'(a) * 16'(b);
            default: return 16'h0000;
        endcase
    endfunction

    // Behavioural ALU: raises done on the Nth consecutive start-high cycle; junk result otherwise.
    int scnt = 0;
    always @(negedge clk) begin
        if (alu_start && reset_n) begin
            scnt = scnt + 1;
            alu_done = (lat_by_op[alu_op] != 0) && (scnt == lat_by_op[alu_op]);
            alu_result = alu_done ? alu_fn(alu_op, alu_a, alu_b) : 16'($urandom);
        end else begin
            scnt = 0;
            alu_done = 1'b0;
            alu_result = 16'($urandom);
        end
    end

    // Monitor: start pulses, alu_reset_n low runs, responses and timeout pulses.
    logic prev_start = 1'b0;
    logic prev_arn = 1'b1;
    int   cur_len = 0;
    int   rlen = 0;
    always @(negedge clk) begin
        if (reset_n) begin
            if (alu_start) begin
                if (!prev_start) begin
                    obs_issue = {obs_issue, $sformatf("%0d:%h:%h ", alu_op, alu_a, alu_b)};
                    cur_len = 0;
                end
                cur_len++;
            end else if (prev_start) begin
                obs_len = {obs_len, $sformatf("%0d ", cur_len)};
            end
            if (!alu_reset_n) begin
                rlen++;
            end else if (!prev_arn) begin
                obs_rst = {obs_rst, $sformatf("%0d ", rlen)};
                rlen = 0;
            end
            if (rsp_valid) begin
                obs_rsp = {obs_rsp, $sformatf("%0d:%h ", rsp_op, rsp_result)};
                last_rsp = {rsp_op, rsp_result};
            end
            if (err_timeout) obs_tmo++;
            prev_start = alu_start;
            prev_arn = alu_reset_n;
        end else begin
            cur_len = 0;
            rlen = 0;
            prev_start = 1'b0;
            prev_arn = 1'b1;
        end
    end

    // Reference model: what each accepted command must produce, by opcode and ALU latency.
    task automatic model_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int lat;
        if (op == 3'b101 || op == 3'b110) return;
        if (op == 3'b111) begin
            exp_rst = {exp_rst, $sformatf("%0d ", RST_CYCLES)};
            return;
        end
        exp_issue = {exp_issue, $sformatf("%0d:%h:%h ", op, a, b)};
        if (op == 3'b000) begin
            exp_len = {exp_len, "1 "};
            return;
        end
        lat = lat_by_op[op];
        if (lat >= 1 && lat <= TIMEOUT) begin
            exp_len = {exp_len, $sformatf("%0d ", lat)};
            exp_rsp = {exp_rsp, $sformatf("%0d:%h ", op, alu_fn(op, a, b))};
        end else begin
            exp_len = {exp_len, $sformatf("%0d ", TIMEOUT)};
            exp_tmo++;
        end
    endtask

    task automatic clear_all();
        obs_issue = ""; exp_issue = "";
        obs_len = "";   exp_len = "";
        obs_rst = "";   exp_rst = "";
        obs_rsp = "";   exp_rsp = "";
        obs_tmo = 0;    exp_tmo = 0;
        last_rsp = '0;
    endtask

    task automatic push_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int g = 0;
        @(negedge clk);
        while (!cmd_ready && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (!cmd_ready) begin
            total++;
            bad++;
            $display("FAIL push_wait cmd_ready stuck low got=0 want=1");
            return;
        end
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_a = a;
        cmd_b = b;
        @(negedge clk);
        cmd_valid = 1'b0;
        model_cmd(op, a, b);
    endtask

    task automatic drain(input string nm);
        int g = 0;
        while ((busy || alu_start) && g < 2000) begin
            @(negedge clk);
            g++;
        end
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (g >= 2000) begin
            bad++;
            $display("FAIL %s_drain busy got=1 want=0", nm);
        end
    endtask

    task automatic test_reset();
        logic [43:0] snap;
        @(negedge clk);
        reset_n = 1'b0;
        cmd_valid = 1'b0;
        #1;
        snap = {cmd_ready, alu_start, alu_a, alu_b, alu_op, alu_reset_n, rsp_valid,
                rsp_result, rsp_op, err_timeout, busy};
        total++;
        if (snap !== {1'b1, 43'b0}) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=%h", snap, {1'b1, 43'b0});
        end
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        total++;
        if (alu_reset_n !== 1'b0) begin
            bad++;
            $display("FAIL reset_alu_rstn_before_clk got=%b want=0", alu_reset_n);
        end
        @(negedge clk);
        #1;
        total++;
        if (alu_reset_n !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release got={arn,busy,rdy}=%b%b%b want=101", alu_reset_n, busy, cmd_ready);
        end
        clear_all();
    endtask

    task automatic test_add();
        for (int i = 0; i < 8; i++) lat_by_op[i] = 1;
        clear_all();
        push_cmd(3'b001, 8'hFF, 8'h01);
        drain("add");
        total++;
        if (obs_len != exp_len) begin bad++; $display("FAIL add_start_len got=%s want=%s", obs_len, exp_len); end
        total++;
        if (obs_rsp != exp_rsp) begin bad++; $display("FAIL add_rsp got=%s want=%s", obs_rsp, exp_rsp); end
        total++;
        if (last_rsp !== {3'b001, 16'h0100}) begin bad++; $display("FAIL add_result got=%h want=%h", last_rsp, {3'b001, 16'h0100}); end
    endtask

    task automatic test_mul();
        lat_by_op[4] = 3;
        clear_all();
        push_cmd(3'b100, 8'd15, 8'd17);
        drain("mul");
        total++;
        if (obs_len != exp_len) begin bad++; $display("FAIL mul_start_len got=%s want=%s", obs_len, exp_len); end
        total++;
        if (last_rsp !== {3'b100, 16'd255}) begin bad++; $display("FAIL mul_result got=%h want=%h", last_rsp, {3'b100, 16'd255}); end
        total++;
        if (obs_tmo != 0) begin bad++; $display("FAIL mul_timeout got=%0d want=0", obs_tmo); end
    endtask

    task automatic test_fifo_full();
        for (int i = 0; i < 8; i++) lat_by_op[i] = 12;
        clear_all();
        for (int k = 0; k < 4; k++) push_cmd(3'b001, 8'(k * 16 + 3), 8'(k + 1));
        #1;
        total++;
        if (cmd_ready !== 1'b1) begin bad++; $display("FAIL full_ready_after4 got=%b want=1", cmd_ready); end
        push_cmd(3'b011, 8'h5A, 8'hC3);
        #1;
        total++;
        if (cmd_ready !== 1'b0 || alu_start !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL full_after5 got={rdy,start,busy}=%b%b%b want=011", cmd_ready, alu_start, busy);
        end
        drain("full");
        total++;
        if (obs_rsp != exp_rsp) begin bad++; $display("FAIL full_rsp_order got=%s want=%s", obs_rsp, exp_rsp); end
        total++;
        if (obs_len != exp_len) begin bad++; $display("FAIL full_start_len got=%s want=%s", obs_len, exp_len); end
    endtask

    task automatic test_timeout();
        lat_by_op[4] = 0;
        lat_by_op[1] = 2;
        lat_by_op[3] = TIMEOUT;
        lat_by_op[2] = TIMEOUT + 1;
        clear_all();
        push_cmd(3'b100, 8'h12, 8'h34);
        push_cmd(3'b001, 8'h40, 8'h02);
        push_cmd(3'b011, 8'h3C, 8'hFF);
        push_cmd(3'b010, 8'hF0, 8'h3C);
        drain("timeout");
        total++;
        if (obs_tmo != exp_tmo) begin bad++; $display("FAIL timeout_count got=%0d want=%0d", obs_tmo, exp_tmo); end
        total++;
        if (obs_len != exp_len) begin bad++; $display("FAIL timeout_start_len got=%s want=%s", obs_len, exp_len); end
        total++;
        if (obs_rsp != exp_rsp) begin bad++; $display("FAIL timeout_rsp got=%s want=%s", obs_rsp, exp_rsp); end
    endtask

    task automatic test_sequence();
        for (int i = 0; i < 8; i++) lat_by_op[i] = 1;
        clear_all();
        push_cmd(3'b000, 8'h11, 8'h22);
        push_cmd(3'b111, 8'h33, 8'h44);
        push_cmd(3'b110, 8'h55, 8'h66);
        push_cmd(3'b011, 8'hAA, 8'h0F);
        drain("seq");
        total++;
        if (obs_issue != exp_issue) begin bad++; $display("FAIL seq_issue got=%s want=%s", obs_issue, exp_issue); end
        total++;
        if (obs_len != exp_len) begin bad++; $display("FAIL seq_start_len got=%s want=%s", obs_len, exp_len); end
        total++;
        if (obs_rst != exp_rst) begin bad++; $display("FAIL seq_rst_len got=%s want=%s", obs_rst, exp_rst); end
        total++;
        if (obs_rsp != exp_rsp || last_rsp !== {3'b011, 16'h00A5}) begin
            bad++;
            $display("FAIL seq_rsp got=%s want=%s", obs_rsp, exp_rsp);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) lat_by_op[i] = $urandom_range(0, TIMEOUT + 2);
        lat_by_op[1] = $urandom_range(1, 4);
        clear_all();
        for (int k = 0; k < 24; k++) begin
            push_cmd(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain("rand");
        total++;
        if (obs_issue != exp_issue) begin bad++; $display("FAIL rand_issue got=%s want=%s", obs_issue, exp_issue); end
        total++;
        if (obs_len != exp_len) begin bad++; $display("FAIL rand_start_len got=%s want=%s", obs_len, exp_len); end
        total++;
        if (obs_rst != exp_rst) begin bad++; $display("FAIL rand_rst_len got=%s want=%s", obs_rst, exp_rst); end
        total++;
        if (obs_rsp != exp_rsp) begin bad++; $display("FAIL rand_rsp got=%s want=%s", obs_rsp, exp_rsp); end
        total++;
        if (obs_tmo != exp_tmo) begin bad++; $display("FAIL rand_timeout got=%0d want=%0d", obs_tmo, exp_tmo); end
    endtask

    task automatic test_reset_mid();
        logic [43:0] snap;
        int g = 0;
        lat_by_op[4] = 0;
        clear_all();
        push_cmd(3'b100, 8'd200, 8'd3);
        push_cmd(3'b001, 8'h01, 8'h02);
        push_cmd(3'b010, 8'h0F, 8'hF0);
        while (!alu_start && g < 50) begin
            @(negedge clk);
            g++;
        end
        total++;
        if (!alu_start) begin bad++; $display("FAIL mid_start_seen got=0 want=1"); end
        repeat (2) @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        snap = {cmd_ready, alu_start, alu_a, alu_b, alu_op, alu_reset_n, rsp_valid,
                rsp_result, rsp_op, err_timeout, busy};
        total++;
        if (snap !== {1'b1, 43'b0}) begin
            bad++;
            $display("FAIL mid_reset_outputs got=%h want=%h", snap, {1'b1, 43'b0});
        end
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        clear_all();
        repeat (30) @(negedge clk);
        #1;
        total++;
        if (obs_issue != "" || obs_rsp != "" || obs_tmo != 0) begin
            bad++;
            $display("FAIL mid_after_release got=issue[%s] rsp[%s] tmo=%0d want=none", obs_issue, obs_rsp, obs_tmo);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) lat_by_op[i] = 1;
        test_reset();
        test_add();
        test_mul();
        test_fifo_full();
        test_timeout();
        test_sequence();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
